// File: rtl/blink_sched_if.sv
// Bundle between status requesters and the shared LED blink scheduler.
// The scheduler sits on the slave side; the requester/bench side uses master.
interface blink_sched_if #(
   parameter int NREQ  = 4,
   parameter int NBITS = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*NBITS-1:0] req_cnt;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  led;
   logic                  flg;
   logic                  done;
   logic                  abort;

   modport master (
      output req, req_cnt,
      input  gnt, busy, led, flg, done, abort
   );

   modport slave (
      input  req, req_cnt,
      output gnt, busy, led, flg, done, abort
   );
endinterface

// File: rtl/blink_sched.sv
// Round-robin scheduler that shares one LED among NREQ requesters, pacing
// each granted blink sequence from a free-running prescaler tick.
//
// state   | meaning
// IDLE    | no grant; round-robin search from ptr
// LOAD    | grant issued, blink count latched (1 cycle)
// WAIT_ON | waiting for the first tick to raise the LED
// ON      | LED high for one tick period
// OFF     | LED low for one tick period
// FIN     | sequence complete; drop grant, pulse done next cycle
module blink_sched #(
   parameter int NREQ  = 4,
   parameter int CBITS = 23,
   parameter int NBITS = 4
) (
   input logic          clk,
   input logic          rst,
   blink_sched_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_ON, ON, OFF, FIN} state_t;

   state_t            state, state_nxt;
   logic [CBITS-1:0]  cnt;
   logic              tick;
   logic              flg;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic [NBITS-1:0]  rem, rem_nxt;
   logic [NREQ-1:0]   gnt, gnt_nxt;
   logic              led, led_nxt;
   logic              done, done_nxt;
   logic              abort, abort_nxt;
   logic              found;
   logic [PW-1:0]     win;
   logic [PW-1:0]     idx;
   logic              held;
   logic [NBITS-1:0]  cnt_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign cnt_arr[i] = bus.req_cnt[i*NBITS +: NBITS];
   end

   assign tick = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         flg <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         flg <= tick;
      end
   end

   // First requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign held = |(bus.req & gnt);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      rem_nxt   = rem;
      ptr_nxt   = ptr;
      led_nxt   = led;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = LOAD;
               gnt_nxt   = NREQ'(1) << win;
               rem_nxt   = cnt_arr[win];
               ptr_nxt   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end
         end
         LOAD, WAIT_ON, ON, OFF: begin
            // A dropped request wins over any tick in the same cycle.
            if (!held) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               led_nxt   = 1'b0;
               rem_nxt   = '0;
               abort_nxt = 1'b1;
            end else if (state == LOAD) begin
               state_nxt = (rem == '0) ? FIN : WAIT_ON;
            end else if (tick && state == WAIT_ON) begin
               led_nxt   = 1'b1;
               state_nxt = ON;
            end else if (tick && state == ON) begin
               led_nxt   = 1'b0;
               rem_nxt   = rem - 1'b1;
               state_nxt = OFF;
            end else if (tick && state == OFF) begin
               if (rem == '0) begin
                  state_nxt = FIN;
               end else begin
                  led_nxt   = 1'b1;
                  state_nxt = ON;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            led_nxt   = 1'b0;
            done_nxt  = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            led_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         rem   <= '0;
         ptr   <= '0;
         led   <= 1'b0;
         done  <= 1'b0;
         abort <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         rem   <= rem_nxt;
         ptr   <= ptr_nxt;
         led   <= led_nxt;
         done  <= done_nxt;
         abort <= abort_nxt;
      end
   end

   assign bus.gnt   = gnt;
   assign bus.led   = led;
   assign bus.flg   = flg;
   assign bus.done  = done;
   assign bus.abort = abort;
   assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched with an 8-cycle tick (CBITS=3).
module tb_blink_sched;
   localparam int NREQ  = 4;
   localparam int CBITS = 3;
   localparam int NBITS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   blink_sched_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

   blink_sched #(.NREQ(NREQ), .CBITS(CBITS), .NBITS(NBITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   int          pulses, width_err, gap_err, done_cnt, abort_cnt, gnt_cyc, onehot_err, led_busy_err;
   logic        first_rise_flg;
   logic [3:0]  last_gnt;
   bit          timed_out;

   task automatic set_cnt(input int i, input logic [NBITS-1:0] v);
      bus.req_cnt[i*NBITS +: NBITS] = v;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.req     = '0;
      bus.req_cnt = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Samples each negedge until done/abort; gathers blink shape statistics.
   task automatic watch(input int budget);
      int   hi;
      int   lo;
      logic prev;
      pulses = 0; width_err = 0; gap_err = 0; done_cnt = 0; abort_cnt = 0;
      gnt_cyc = 0; onehot_err = 0; led_busy_err = 0; last_gnt = '0;
      first_rise_flg = 1'b0; timed_out = 1'b1;
      hi = 0; lo = 0; prev = bus.led;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.gnt != '0) begin
            gnt_cyc++;
            last_gnt = bus.gnt;
         end
         if (!$onehot0(bus.gnt)) onehot_err++;
         if (bus.led && !bus.busy) led_busy_err++;
         if (bus.done) done_cnt++;
         if (bus.abort) abort_cnt++;
         if (bus.led && !prev) begin
            if (pulses == 0) first_rise_flg = bus.flg;
            else if (lo != 8) gap_err++;
            pulses++;
            hi = 0;
         end
         if (!bus.led && prev) begin
            if (hi != 8) width_err++;
            lo = 0;
         end
         if (bus.led) hi++; else lo++;
         prev = bus.led;
         if (bus.done || bus.abort) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.req = '0;
      bus.req_cnt = '0;
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt got %b expected 0000", bus.gnt); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else passed++;
      total++; if (bus.led !== 1'b0) $display("FAIL reset_led got %b expected 0", bus.led); else passed++;
      total++; if (bus.flg !== 1'b0) $display("FAIL reset_flg got %b expected 0", bus.flg); else passed++;
      total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b expected 0", bus.done); else passed++;
      total++; if (bus.abort !== 1'b0) $display("FAIL reset_abort got %b expected 0", bus.abort); else passed++;
   endtask

   task automatic test_prescaler();
      int n_flg;
      int last;
      int bad_gap;
      int led_seen;
      int busy_seen;
      do_reset();
      n_flg = 0; last = -1; bad_gap = 0; led_seen = 0; busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.flg) begin
            if (last >= 0 && i - last != 8) bad_gap++;
            last = i;
            n_flg++;
         end
         if (bus.led) led_seen++;
         if (bus.busy) busy_seen++;
      end
      total++; if (n_flg != 5) $display("FAIL presc_flg_count got %0d expected 5", n_flg); else passed++;
      total++; if (bad_gap != 0) $display("FAIL presc_flg_spacing got %0d bad gaps expected 0", bad_gap); else passed++;
      total++; if (led_seen != 0) $display("FAIL presc_led got %0d high cycles expected 0", led_seen); else passed++;
      total++; if (busy_seen != 0) $display("FAIL presc_busy got %0d busy cycles expected 0", busy_seen); else passed++;
   endtask

   task automatic test_single();
      do_reset();
      set_cnt(0, 4'd2);
      bus.req = 4'b0001;
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0001) $display("FAIL single_gnt got %b expected 0001", bus.gnt); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got %b expected 1", bus.busy); else passed++;
      watch(400);
      total++; if (timed_out) $display("FAIL single_timeout got timeout expected done"); else passed++;
      total++; if (pulses != 2) $display("FAIL single_pulses got %0d expected 2", pulses); else passed++;
      total++; if (width_err != 0) $display("FAIL single_width got %0d bad widths expected 0", width_err); else passed++;
      total++; if (gap_err != 0) $display("FAIL single_gap got %0d bad gaps expected 0", gap_err); else passed++;
      total++; if (first_rise_flg !== 1'b1) $display("FAIL single_rise_on_tick got flg=%b expected 1", first_rise_flg); else passed++;
      total++; if (done_cnt != 1) $display("FAIL single_done got %0d expected 1", done_cnt); else passed++;
      total++; if (abort_cnt != 0) $display("FAIL single_abort got %0d expected 0", abort_cnt); else passed++;
      total++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) $display("FAIL single_end got gnt=%b busy=%b expected 0000/0", bus.gnt, bus.busy); else passed++;
      total++; if (led_busy_err != 0) $display("FAIL single_led_outside_seq got %0d expected 0", led_busy_err); else passed++;
      bus.req = '0;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) $display("FAIL single_no_regrant got busy=%b expected 0", bus.busy); else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt [4];
      int w;
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b1000; exp_gnt[3] = 4'b0001;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_cnt(i, 4'd1);
      bus.req = 4'b1011;
      for (int s = 0; s < 4; s++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (bus.gnt == '0 && w < 50);
         total++; if (bus.gnt !== exp_gnt[s]) $display("FAIL rr_order[%0d] got %b expected %b", s, bus.gnt, exp_gnt[s]); else passed++;
         watch(200);
         total++; if (timed_out || done_cnt != 1 || abort_cnt != 0) $display("FAIL rr_done[%0d] got done=%0d abort=%0d timeout=%0b expected 1/0/0", s, done_cnt, abort_cnt, timed_out); else passed++;
         total++; if (pulses != 1 || onehot_err != 0) $display("FAIL rr_seq[%0d] got pulses=%0d onehot_err=%0d expected 1/0", s, pulses, onehot_err); else passed++;
      end
      bus.req = '0;
      @(negedge clk);
   endtask

   task automatic test_zero();
      do_reset();
      set_cnt(2, 4'd0);
      bus.req = 4'b0100;
      watch(50);
      total++; if (timed_out) $display("FAIL zero_timeout got timeout expected done"); else passed++;
      total++; if (gnt_cyc != 2) $display("FAIL zero_gnt_cycles got %0d expected 2", gnt_cyc); else passed++;
      total++; if (last_gnt !== 4'b0100) $display("FAIL zero_gnt got %b expected 0100", last_gnt); else passed++;
      total++; if (pulses != 0) $display("FAIL zero_led got %0d pulses expected 0", pulses); else passed++;
      total++; if (done_cnt != 1) $display("FAIL zero_done got %0d expected 1", done_cnt); else passed++;
      bus.req = '0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      int w;
      do_reset();
      set_cnt(0, 4'd5);
      set_cnt(1, 4'd1);
      bus.req = 4'b0011;
      w = 0;
      while (bus.led !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      total++; if (w >= 200) $display("FAIL abort_wait_led got timeout expected led=1"); else passed++;
      bus.req = 4'b0010;
      @(negedge clk);
      total++; if (bus.led !== 1'b0 || bus.gnt !== 4'b0) $display("FAIL abort_clear got led=%b gnt=%b expected 0/0000", bus.led, bus.gnt); else passed++;
      total++; if (bus.abort !== 1'b1 || bus.done !== 1'b0) $display("FAIL abort_pulse got abort=%b done=%b expected 1/0", bus.abort, bus.done); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b expected 0", bus.busy); else passed++;
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0010 || bus.abort !== 1'b0) $display("FAIL abort_next_gnt got gnt=%b abort=%b expected 0010/0", bus.gnt, bus.abort); else passed++;
      watch(200);
      total++; if (timed_out || done_cnt != 1 || abort_cnt != 0 || pulses != 1) $display("FAIL abort_follow got done=%0d abort=%0d pulses=%0d expected 1/0/1", done_cnt, abort_cnt, pulses); else passed++;
      bus.req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int w;
      do_reset();
      set_cnt(0, 4'd3);
      bus.req = 4'b0001;
      w = 0;
      while (bus.led !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      total++; if (w >= 200) $display("FAIL rstmid_wait_led got timeout expected led=1"); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if (bus.led !== 1'b0 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) $display("FAIL rstmid_async got led=%b gnt=%b busy=%b expected 0/0000/0", bus.led, bus.gnt, bus.busy); else passed++;
      total++; if (bus.flg !== 1'b0 || bus.done !== 1'b0 || bus.abort !== 1'b0) $display("FAIL rstmid_pulses got flg=%b done=%b abort=%b expected 0/0/0", bus.flg, bus.done, bus.abort); else passed++;
      @(negedge clk);
      rst = 1'b0;
      set_cnt(0, 4'd1);
      set_cnt(3, 4'd1);
      bus.req = 4'b1001;
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0001) $display("FAIL rstmid_ptr got gnt=%b expected 0001", bus.gnt); else passed++;
      bus.req = '0;
      @(negedge clk);
   endtask

   initial begin
      bus.req     = '0;
      bus.req_cnt = '0;
      test_reset();
      test_prescaler();
      test_single();
      test_round_robin();
      test_zero();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
